comb_sweep_checker: RTL and testbench
=====================================

# comb_sweep_checker

Self-checking exhaustive stimulus stage for 5-input combinational gate blocks.
- Upstream: drives the DUT inputs a..e through all 32 codes.
- Downstream: samples the DUT output f after each code, assembles the 32-entry truth table and compares it against an expected table.
- Synthesizable replacement for bench-only `for`-loop sweeps; used on-board to verify gate logic and report pass/fail.

## Interface
- `SETTLE`, default 2: extra cycles each vector is held before `f_in` is sampled. Legal range 0..15.
- `EXPECTED`, default 32'h9669_6996: expected truth table. Bit i is the required `f` for input code i.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a sweep. Sampled only in IDLE.
- `abcde`  out  5  applied input code. Bit 4 = a, bit 3 = b, bit 2 = c, bit 1 = d, bit 0 = e.
- `f_in`  in  1  DUT output, combinationally derived from `abcde`.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `table_q`  out  32  captured truth table. Bit i = sampled `f_in` for code i.
- `pass`  out  1  high when `table_q == EXPECTED`. Valid from `done` until the next accepted `start`.
- `mismatch_cnt`  out  6  number of differing bits, 0..32.
- `first_fail`  out  5  lowest mismatching code. Reads 0 when `pass` = 1.

## Operation
- Reset values: every output is 0, and the FSM is in IDLE.
- FSM states: IDLE, HOLD, SAMPLE.
- IDLE → HOLD: when `start` = 1. On that edge:
  - `abcde` <= 0, `busy` <= 1, settle counter <= `SETTLE`.
  - `table_q`, `pass`, `mismatch_cnt` and `first_fail` are cleared.
- HOLD:
  - Decrement the settle counter each cycle.
  - Go to SAMPLE when the counter is 0. With `SETTLE` = 0, HOLD lasts exactly one cycle.
- SAMPLE (one cycle), with i = current `abcde`:
  - `table_q[i]` <= `f_in`.
  - If `f_in != EXPECTED[i]`: increment `mismatch_cnt`; if this is the first mismatch of the sweep, `first_fail` <= i.
  - If i < 31: `abcde` <= i+1, reload the settle counter, go to HOLD.
  - If i = 31: go to IDLE with `busy` <= 0, `done` <= 1 for one cycle, and `pass` <= (no mismatch, including the final sample). `abcde` holds 31.
- `start` while `busy` = 1 is ignored.
- `start` high in the `done` cycle is accepted, since the FSM is already in IDLE. A new sweep begins and the results are cleared.
- Reset mid-sweep: asynchronous return to all reset values. The partial table is discarded.
- Width rules:
  - The 5-bit index must not wrap. The last-code test is on i = 31, before any increment.
  - `mismatch_cnt` is 6 bits so that 32 mismatches are representable.

## Timing
- Each code is driven for `SETTLE`+2 cycles: the HOLD cycles plus the SAMPLE cycle.
- `f_in` is registered at the edge that ends SAMPLE.
- Let edge 0 be the edge that accepts `start`:
  - Code i is sampled at edge (i+1)·(`SETTLE`+2).
  - `done` is high in the cycle that follows edge 32·(`SETTLE`+2).
  - With `SETTLE` = 2, that is edge 128.
- `busy` rises after edge 0 and falls together with the rise of `done`.
- The result outputs are registered and stable while `busy` = 0.

## Structure
- Package `comb_sweep_pkg` holds:
  - the state enum `sweep_state_t` (IDLE, HOLD, SAMPLE);
  - `VEC_W` = 5 and `N_VEC` = 32;
  - the widths of `mismatch_cnt` and the settle counter.
- Sub-module `sweep_settle_timer`: a loadable 4-bit down-counter with a zero flag, instantiated once.
- The FSM and result accumulation live in the top module.

## Test plan
- Parity DUT model (`f_in` = ^`abcde`), `EXPECTED` = 32'h9669_6996, `SETTLE` = 2, single `start` pulse → `table_q` = 32'h9669_6996, `pass` = 1, `mismatch_cnt` = 0, `first_fail` = 0, `done` one cycle after edge 128.
- `f_in` tied to 0 with the same `EXPECTED` → `table_q` = 0, `pass` = 0, `mismatch_cnt` = 16, `first_fail` = 1.
- `SETTLE` = 0, AND5 model, `EXPECTED` = 32'h8000_0000 → `pass` = 1, `done` one cycle after edge 64, `abcde` steps every 2 cycles.
- `start` pulsed again at edge 40 of a sweep → ignored, and `done` timing is unchanged. `start` held high into the `done` cycle → a second sweep starts immediately with the results cleared.
- `rst_n` low at edge 50 → `abcde` = 0, `busy` = 0, `table_q` = 0 immediately, before the next clock edge. A subsequent `start` gives a full, correct sweep.
- Parity model with bit 31 of `EXPECTED` flipped → `mismatch_cnt` = 1, `first_fail` = 31, `pass` = 0. This checks that the last code is counted and that the index does not wrap.

Source files
------------

// File: rtl/comb_sweep_pkg.sv
// comb_sweep_pkg: shared types and widths for the exhaustive 5-input sweep checker
package comb_sweep_pkg;
    localparam int VEC_W = 5;
    localparam int N_VEC = 32;
    localparam int CNT_W = 6;
    localparam int SET_W = 4;
    typedef enum logic [1:0] {IDLE, HOLD, SAMPLE} sweep_state_t;
endpackage

// File: rtl/comb_sweep_checker_timer.sv
// sweep_settle_timer: loadable down-counter with a zero flag for per-vector settling
module sweep_settle_timer
    import comb_sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [SET_W-1:0] load_val,
    output logic             zero
);
    logic [SET_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load ? load_val : dec ? cnt_q - SET_W'(1) : cnt_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    assign zero = cnt_q == '0;
endmodule

// File: rtl/comb_sweep_checker.sv
// comb_sweep_checker: drives all 32 input codes, captures f and compares against EXPECTED
module comb_sweep_checker
    import comb_sweep_pkg::*;
#(
    parameter int          SETTLE   = 2,
    parameter logic [31:0] EXPECTED = 32'h9669_6996
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [VEC_W-1:0] abcde,
    input  logic             f_in,
    output logic             busy,
    output logic             done,
    output logic [N_VEC-1:0] table_q,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [VEC_W-1:0] first_fail
);
    sweep_state_t     state_q, state_d;
    logic [VEC_W-1:0] abcde_q, abcde_d, ff_q, ff_d;
    logic [N_VEC-1:0] table_d;
    logic [CNT_W-1:0] mm_q, mm_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic             tmr_load, tmr_dec, tmr_zero, last, miss;
    sweep_settle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (SET_W'(SETTLE)),
        .zero     (tmr_zero)
    );
    always_comb begin
        state_d  = state_q;
        abcde_d  = abcde_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        table_d  = table_q;
        pass_d   = pass_q;
        mm_d     = mm_q;
        ff_d     = ff_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        last     = abcde_q == VEC_W'(N_VEC - 1);
        miss     = f_in != EXPECTED[abcde_q];
        case (state_q)
            IDLE: if (start) begin
                state_d  = HOLD;
                abcde_d  = '0;
                busy_d   = 1'b1;
                tmr_load = 1'b1;
                table_d  = '0;
                pass_d   = 1'b0;
                mm_d     = '0;
                ff_d     = '0;
            end
            HOLD: if (tmr_zero) state_d = SAMPLE;
                  else          tmr_dec = 1'b1;
            SAMPLE: begin
                table_d[abcde_q] = f_in;
                if (miss) begin
                    mm_d = mm_q + CNT_W'(1);
                    if (mm_q == '0) ff_d = abcde_q;
                end
                if (last) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = mm_d == '0;
                end else begin
                    state_d  = HOLD;
                    abcde_d  = abcde_q + VEC_W'(1);
                    tmr_load = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            abcde_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            table_q <= '0;
            pass_q  <= 1'b0;
            mm_q    <= '0;
            ff_q    <= '0;
        end else begin
            state_q <= state_d;
            abcde_q <= abcde_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            table_q <= table_d;
            pass_q  <= pass_d;
            mm_q    <= mm_d;
            ff_q    <= ff_d;
        end
    assign abcde        = abcde_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign mismatch_cnt = mm_q;
    assign first_fail   = ff_q;
endmodule

// File: tb/tb_comb_sweep_checker.sv
// tb_comb_sweep_checker: directed and randomized sweeps checked against a truth-table reference
module tb_comb_sweep_checker;
    localparam logic [31:0] EXP0 = 32'h9669_6996;
    localparam logic [31:0] EXP1 = 32'h8000_0000;
    logic        clk = 1'b0, rst_n = 1'b0, start0 = 1'b0, start1 = 1'b0;
    logic [4:0]  abcde0, abcde1, ff0, ff1;
    logic        f0, f1, busy0, busy1, done0, done1, pass0, pass1;
    logic [31:0] table0, table1, tbl0;
    logic [5:0]  mm0, mm1;
    int          checks = 0, errors = 0, n;
    always #5 clk = ~clk;
    assign f0 = tbl0[abcde0];
    assign f1 = &abcde1;
    comb_sweep_checker u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abcde(abcde0), .f_in(f0),
        .busy(busy0), .done(done0), .table_q(table0), .pass(pass0),
        .mismatch_cnt(mm0), .first_fail(ff0)
    );
    comb_sweep_checker #(.SETTLE(0), .EXPECTED(EXP1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abcde(abcde1), .f_in(f1),
        .busy(busy1), .done(done1), .table_q(table1), .pass(pass1),
        .mismatch_cnt(mm1), .first_fail(ff1)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic logic [31:0] gate_tbl(input bit use_and);
        logic [31:0] t;
        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            v = i[4:0];
            t[i] = use_and ? &v : ^v;
        end
        return t;
    endfunction
    function automatic logic [4:0] ref_ff(input logic [31:0] t, input logic [31:0] e);
        for (int i = 0; i < 32; i++) if (t[i] != e[i]) return i[4:0];
        return 5'd0;
    endfunction
    task automatic check_results0(input string tag);
        chk({tag, "_table"}, table0, tbl0);
        chk({tag, "_mm"}, {26'd0, mm0}, $countones(tbl0 ^ EXP0));
        chk({tag, "_ff"}, {27'd0, ff0}, {27'd0, ref_ff(tbl0, EXP0)});
        chk({tag, "_pass"}, {31'd0, pass0}, {31'd0, tbl0 == EXP0});
        chk({tag, "_busy"}, {31'd0, busy0}, 32'd0);
    endtask
    task automatic sweep0(input int pulse_at, input bit hold, output int edges);
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        edges = 0;
        while (edges < 2000) begin
            @(negedge clk);
            if (done0) break;
            start0 = hold || (edges + 1 == pulse_at);
            @(posedge clk);
            edges++;
        end
        if (!hold) start0 = 1'b0;
    endtask
    task automatic run0(input string tag, input logic [31:0] t, input int pulse_at);
        tbl0 = t;
        sweep0(pulse_at, 1'b0, n);
        chk({tag, "_done_edge"}, n, 128);
        check_results0(tag);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, done0}, 32'd0);
    endtask
    initial begin
        tbl0 = gate_tbl(1'b0);
        #2;
        chk("rst_abcde", {27'd0, abcde0}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_done", {31'd0, done0}, 32'd0);
        chk("rst_table", table0, 32'd0);
        chk("rst_pass", {31'd0, pass0}, 32'd0);
        chk("rst_mm", {26'd0, mm0}, 32'd0);
        chk("rst_ff", {27'd0, ff0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run0("parity", gate_tbl(1'b0), 0);
        chk("parity_pass_const", {31'd0, pass0}, 32'd1);
        run0("zero", 32'd0, 0);
        chk("zero_mm_const", {26'd0, mm0}, 32'd16);
        chk("zero_ff_const", {27'd0, ff0}, 32'd1);
        for (int k = 0; k < 3; k++) run0("random", $urandom, 0);
        run0("last_code", gate_tbl(1'b0) ^ 32'h8000_0000, 0);
        chk("last_mm_const", {26'd0, mm0}, 32'd1);
        chk("last_ff_const", {27'd0, ff0}, 32'd31);
        run0("restart_ignored", gate_tbl(1'b0), 40);
        tbl0 = $urandom;
        sweep0(0, 1'b1, n);
        chk("hold_done_edge", n, 128);
        check_results0("hold_first");
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        chk("hold_busy", {31'd0, busy0}, 32'd1);
        chk("hold_done", {31'd0, done0}, 32'd0);
        chk("hold_table", table0, 32'd0);
        chk("hold_mm", {26'd0, mm0}, 32'd0);
        chk("hold_pass", {31'd0, pass0}, 32'd0);
        chk("hold_abcde", {27'd0, abcde0}, 32'd0);
        n = 0;
        while (!done0 && n < 2000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("hold_second_done_edge", n, 128);
        check_results0("hold_second");
        tbl0 = gate_tbl(1'b0);
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        repeat (50) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_abcde", {27'd0, abcde0}, 32'd0);
        chk("arst_busy", {31'd0, busy0}, 32'd0);
        chk("arst_table", table0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run0("after_reset", gate_tbl(1'b0), 0);
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 2000) begin
            chk("and5_abcde", {27'd0, abcde1}, n / 2);
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("and5_done_edge", n, 64);
        chk("and5_table", table1, gate_tbl(1'b1));
        chk("and5_pass", {31'd0, pass1}, 32'd1);
        chk("and5_mm", {26'd0, mm1}, 32'd0);
        chk("and5_ff", {27'd0, ff1}, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
